mc_control_fsm: RTL and testbench

//  Multi-cycle main controller for the RV32I core: sequences one shared ALU, one unified

---
 rtl/mc_control_fsm.sv | 242 ++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I main controller: sequences ALU, unified memory port and register file.
// Optional retired-instruction / cycle counters are enabled by defining MC_CTRL_PERF_CNT_EN.
module mc_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic               illegal,
`ifdef MC_CTRL_PERF_CNT_EN
  output logic [31:0]        instret,
  output logic [31:0]        cycles,
`endif
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JAL_LNK  = 4'd11,
    S_JALR_ADR = 4'd12,
    S_JALR_LNK = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_R     = 7'd51;
  localparam logic [6:0] OP_I     = 7'd19;
  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;
  localparam logic [6:0] OP_BR    = 7'd99;
  localparam logic [6:0] OP_JAL   = 7'd111;
  localparam logic [6:0] OP_JALR  = 7'd103;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state, state_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // NOTE: every output and state_next gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = 2'b00;

    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
        case (op)
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_BR:             state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR_ADR;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = (op == OP_STORE) ? 2'b01 : 2'b00;
        state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = mem_ready;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        state_next = S_ALUWB;
        case (funct3)
          3'b000:  ALUControl = funct7 ? ALU_SUB : ALU_ADD;
          3'b111:  ALUControl = ALU_AND;
          3'b110:  ALUControl = ALU_OR;
          3'b010:  ALUControl = ALU_SLT;
          default: state_next = S_TRAP;
        endcase
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = S_ALUWB;
        case (funct3)
          3'b000:  ALUControl = ALU_ADD;
          3'b111:  ALUControl = ALU_AND;
          3'b110:  ALUControl = ALU_OR;
          3'b010:  ALUControl = ALU_SLT;
          default: state_next = S_TRAP;
        endcase
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        state_next = S_FETCH;
        case (funct3)
          3'b000:  PCWrite    = zero;
          3'b001:  PCWrite    = ~zero;
          default: state_next = S_TRAP;
        endcase
      end
      S_JAL: begin
        // Target OldPC+immJ goes straight to PC; the link value is formed next cycle.
        ImmSrc     = 2'b11;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        PCWrite    = 1'b1;
        state_next = S_JAL_LNK;
      end
      S_JAL_LNK, S_JALR_LNK: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_JALR_ADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        PCWrite    = 1'b1;
        state_next = S_JALR_LNK;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase

    // Reset abandons the current instruction: no enable may fire in the reset cycle.
    if (rst) begin
      state_next = S_FETCH;
      mem_req    = 1'b0;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      ImmSrc     = 2'b00;
    end
  end

  assign illegal = ~rst & (state == S_TRAP);
  assign state_o = rst ? '0 : STATE_W'(state);

`ifdef MC_CTRL_PERF_CNT_EN
  logic retire;

  always_comb begin
    retire = 1'b0;
    if (!rst && state_next == S_FETCH) begin
      case (state)
        S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_JAL_LNK, S_JALR_LNK: retire = 1'b1;
        default:                                                      retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= '0;
      cycles  <= '0;
    end else begin
      cycles  <= cycles + 32'd1;
      instret <= instret + {31'd0, retire};
    end
  end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-instruction cycle model compared every cycle.
// Define MC_CTRL_PERF_CNT_EN to also check the instret/cycles counters.
module tb_mc_control_fsm;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,   S_MEMADR = 4'd2,  S_MEMREAD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR = 4'd6,   S_EXECI = 4'd7;
  localparam logic [3:0] S_ALUWB = 4'd8,  S_BRANCH = 4'd9,   S_JAL = 4'd10,    S_JAL_LNK = 4'd11;
  localparam logic [3:0] S_JALR_ADR = 4'd12, S_JALR_LNK = 4'd13, S_TRAP = 4'd14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7 = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] instret, cycles;
`endif

  mc_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .illegal(illegal),
`ifdef MC_CTRL_PERF_CNT_EN
    .instret(instret), .cycles(cycles),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, mem_ready, zero;
    logic [6:0] op; logic [2:0] f3; logic f7;
    logic mem_req, pcw, adr, irw, mw, rw;
    logic [1:0] res, sa, sb; logic [2:0] alu; logic [1:0] imm;
    logic ill; logic [3:0] st; logic retire;
  } cyc_t;

  cyc_t q[$];
  int checks = 0, passes = 0, cyc_no = 0;
  int rw_cnt, pcw_cnt, mw_cnt, ill_cnt, n;
  logic [2:0] last_execr_alu;
  logic [6:0] cur_op; logic [2:0] cur_f3; logic cur_f7, cur_z;
  logic [31:0] exp_cycles = 0, exp_instret = 0;
  bit cnt_valid = 0;

  logic [21:0] dut_v;
  assign dut_v = {mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, state_o};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [21:0] exp_v(input cyc_t c);
    return {c.mem_req, c.pcw, c.adr, c.irw, c.mw, c.rw, c.res, c.sa, c.sb, c.alu, c.imm, c.ill, c.st};
  endfunction

  function automatic cyc_t blank(input logic [3:0] st);
    cyc_t c;
    c = '{default: '0};
    c.mem_ready = 1'b1; c.st = st;
    c.op = cur_op; c.f3 = cur_f3; c.f7 = cur_f7; c.zero = cur_z;
    return c;
  endfunction

  // ALU code from the instruction fields; -1 marks an unsupported encoding.
  function automatic int alu_code(input logic [2:0] f3, input logic f7, input bit rtype);
    case (f3)
      3'b000:  return (rtype && f7) ? 1 : 0;
      3'b111:  return 2;
      3'b110:  return 3;
      3'b010:  return 5;
      default: return -1;
    endcase
  endfunction

  task automatic p_rst();
    cyc_t c;
    c = blank(S_FETCH); c.rst = 1'b1; q.push_back(c);
  endtask

  task automatic p_fetch(input int waits);
    cyc_t c;
    for (int i = 0; i <= waits; i++) begin
      c = blank(S_FETCH); c.mem_req = 1; c.sb = 2'b10; c.res = 2'b10;
      if (i < waits) c.mem_ready = 1'b0;
      else begin c.irw = 1; c.pcw = 1; end
      q.push_back(c);
    end
  endtask

  task automatic p_mem(input bit write, input int waits);
    cyc_t c;
    for (int i = 0; i <= waits; i++) begin
      c = blank(write ? S_MEMWRITE : S_MEMREAD); c.mem_req = 1; c.adr = 1;
      if (i < waits) c.mem_ready = 1'b0;
      else if (write) begin c.mw = 1; c.retire = 1; end
      q.push_back(c);
    end
  endtask

  task automatic p_trap(input int cyc);
    cyc_t c;
    for (int i = 0; i < cyc; i++) begin
      c = blank(S_TRAP); c.ill = 1; q.push_back(c);
    end
    p_rst();
  endtask

  task automatic p_wb(input logic [3:0] st, input logic [1:0] res);
    cyc_t c;
    c = blank(st); c.res = res; c.rw = 1; c.retire = 1; q.push_back(c);
  endtask

  // Expected cycle sequence for one whole instruction; nout = cycles it takes.
  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                       input int fw, input int mwait, output int nout);
    cyc_t c; int start; int code;
    start = q.size();
    cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_z = z;
    p_fetch(fw);
    c = blank(S_DECODE); c.sa = 2'b01; c.sb = 2'b01; c.imm = 2'b10; q.push_back(c);
    case (o)
      7'd51, 7'd19: begin
        code = alu_code(f3, f7, o == 7'd51);
        c = blank(o == 7'd51 ? S_EXECR : S_EXECI); c.sa = 2'b10;
        c.sb = (o == 7'd51) ? 2'b00 : 2'b01;
        if (code >= 0) c.alu = code[2:0];
        q.push_back(c);
        if (code >= 0) p_wb(S_ALUWB, 2'b00); else p_trap(10);
      end
      7'd3, 7'd35: begin
        c = blank(S_MEMADR); c.sa = 2'b10; c.sb = 2'b01; c.imm = (o == 7'd35) ? 2'b01 : 2'b00;
        q.push_back(c);
        p_mem(o == 7'd35, mwait);
        if (o == 7'd3) p_wb(S_MEMWB, 2'b01);
      end
      7'd99: begin
        c = blank(S_BRANCH); c.sa = 2'b10; c.alu = 3'b001;
        if (f3 == 3'b000) c.pcw = z;
        if (f3 == 3'b001) c.pcw = ~z;
        c.retire = (f3 == 3'b000 || f3 == 3'b001);
        q.push_back(c);
        if (!c.retire) p_trap(10);
      end
      7'd111: begin
        c = blank(S_JAL); c.imm = 2'b11; c.sa = 2'b01; c.sb = 2'b01; c.res = 2'b10; c.pcw = 1;
        q.push_back(c);
        c = blank(S_JAL_LNK); c.sa = 2'b01; c.sb = 2'b10; c.res = 2'b10; c.rw = 1; c.retire = 1;
        q.push_back(c);
      end
      7'd103: begin
        c = blank(S_JALR_ADR); c.sa = 2'b10; c.sb = 2'b01; c.res = 2'b10; c.pcw = 1;
        q.push_back(c);
        c = blank(S_JALR_LNK); c.sa = 2'b01; c.sb = 2'b10; c.res = 2'b10; c.rw = 1; c.retire = 1;
        q.push_back(c);
      end
      default: p_trap(10);
    endcase
    nout = q.size() - start;
  endtask

  task automatic clr_cnt();
    rw_cnt = 0; pcw_cnt = 0; mw_cnt = 0; ill_cnt = 0; last_execr_alu = 3'b111;
  endtask

  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(posedge clk); #1;
      rst = c.rst; mem_ready = c.mem_ready; zero = c.zero;
      op = c.op; funct3 = c.f3; funct7 = c.f7;
      @(negedge clk);
      cyc_no++;
      check($sformatf("cycle%0d", cyc_no), {10'd0, dut_v}, {10'd0, exp_v(c)});
      if (RegWrite === 1'b1) rw_cnt++;
      if (PCWrite === 1'b1) pcw_cnt++;
      if (MemWrite === 1'b1) mw_cnt++;
      if (illegal === 1'b1) ill_cnt++;
      if (state_o === S_EXECR) last_execr_alu = ALUControl;
`ifdef MC_CTRL_PERF_CNT_EN
      if (cnt_valid) begin
        check($sformatf("cycles%0d", cyc_no), cycles, exp_cycles);
        check($sformatf("instret%0d", cyc_no), instret, exp_instret);
      end
      if (c.rst) begin exp_cycles = 0; exp_instret = 0; cnt_valid = 1; end
      else begin exp_cycles++; if (c.retire) exp_instret++; end
`endif
    end
  endtask

  initial begin
    cur_op = '0; cur_f3 = '0; cur_f7 = 1'b0; cur_z = 1'b0;
    clr_cnt();
    p_rst(); p_rst(); run_q();

    // add x3,x1,x2
    clr_cnt(); instr(7'd51, 3'b000, 1'b0, 1'b0, 0, 0, n); run_q();
    check("add_len", n, 4); check("add_regwrite", rw_cnt, 1);
    check("add_aluctl", {29'd0, last_execr_alu}, 32'd0);

    // other R and I-type ALU ops, one with fetch wait states
    instr(7'd51, 3'b000, 1'b1, 1'b0, 0, 0, n);
    instr(7'd51, 3'b111, 1'b0, 1'b0, 0, 0, n);
    instr(7'd51, 3'b110, 1'b0, 1'b0, 1, 0, n);
    instr(7'd51, 3'b010, 1'b0, 1'b0, 0, 0, n);
    instr(7'd19, 3'b000, 1'b1, 1'b0, 2, 0, n);
    instr(7'd19, 3'b111, 1'b0, 1'b0, 0, 0, n);
    instr(7'd19, 3'b010, 1'b0, 1'b0, 0, 0, n);
    run_q();
    check("addi_wait_len", n, 4);

    // lw with three wait states in MEMREAD
    clr_cnt(); instr(7'd3, 3'b010, 1'b0, 1'b0, 0, 3, n); run_q();
    check("lw_len", n, 8); check("lw_regwrite", rw_cnt, 1);

    // beq / bne with both zero values
    clr_cnt(); instr(7'd99, 3'b000, 1'b0, 1'b1, 0, 0, n); run_q();
    check("beq_taken_len", n, 3); check("beq_taken_pcw", pcw_cnt, 2);
    clr_cnt(); instr(7'd99, 3'b000, 1'b0, 1'b0, 0, 0, n); run_q();
    check("beq_not_pcw", pcw_cnt, 1);
    clr_cnt(); instr(7'd99, 3'b001, 1'b0, 1'b1, 0, 0, n); run_q();
    check("bne_not_pcw", pcw_cnt, 1);
    clr_cnt(); instr(7'd99, 3'b001, 1'b0, 1'b0, 0, 0, n); run_q();
    check("bne_taken_pcw", pcw_cnt, 2);

    // sw with one wait state
    clr_cnt(); instr(7'd35, 3'b010, 1'b0, 1'b0, 0, 1, n); run_q();
    check("sw_len", n, 5); check("sw_memwrite", mw_cnt, 1); check("sw_regwrite", rw_cnt, 0);

    // jal / jalr
    clr_cnt(); instr(7'd111, 3'b000, 1'b0, 1'b0, 0, 0, n); run_q();
    check("jal_len", n, 4);
    instr(7'd103, 3'b000, 1'b0, 1'b0, 0, 0, n); run_q();
    check("jalr_len", n, 4);

    // unsupported opcode: trap for 10 cycles, then reset
    clr_cnt(); instr(7'h7F, 3'b000, 1'b0, 1'b0, 0, 0, n); run_q();
    check("trap_illegal_cycles", ill_cnt, 10); check("trap_regwrite", rw_cnt, 0);

    // unsupported funct3 in EXECR, EXECI and BRANCH
    instr(7'd51, 3'b001, 1'b0, 1'b0, 0, 0, n);
    instr(7'd19, 3'b011, 1'b0, 1'b0, 0, 0, n);
    instr(7'd99, 3'b100, 1'b0, 1'b1, 0, 0, n);
    instr(7'd51, 3'b000, 1'b0, 1'b0, 0, 0, n);
    run_q();

    // reset pulsed while in EXECR: instruction abandoned, next add completes normally
    clr_cnt();
    cur_op = 7'd51; cur_f3 = 3'b000; cur_f7 = 1'b0; cur_z = 1'b0;
    p_fetch(0);
    begin
      cyc_t c;
      c = blank(S_DECODE); c.sa = 2'b01; c.sb = 2'b01; c.imm = 2'b10; q.push_back(c);
    end
    p_rst();
    instr(7'd51, 3'b000, 1'b0, 1'b0, 0, 0, n);
    run_q();
    check("rst_execr_regwrite", rw_cnt, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
